// File: rtl/pipeline_interlock_ctrl.sv
// pipeline_interlock_ctrl: merges load-use, branch-flush and MDU interlocks into IF/ID strobes
// and sequences the multi-cycle MDU busy/latency counter.
module pipeline_interlock_ctrl #(
    parameter int REG_W      = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_Rt,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_MDUStart,
    input  logic             IF_ID_MDUDiv,
    input  logic             IF_ID_ReadHiLo,
    input  logic             Branch_Taken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             Stall,
    output logic             MDU_Issue,
    output logic             MDU_Busy,
    output logic             MDU_Done
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic w_lu, w_mi, w_stall;
    assign w_lu = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                  ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
    assign w_mi = MDU_Busy && (IF_ID_MDUStart || IF_ID_ReadHiLo);
    // reset forces the pipeline to free-run, so every stall source is masked by it
    assign w_stall     = ~reset && (w_lu || w_mi);
    assign PCWrite     = ~w_stall;
    assign IF_ID_Write = ~w_stall;
    assign Stall       = w_stall;
    assign IF_ID_Flush = Branch_Taken && ~w_stall && ~reset;
    assign MDU_Issue   = IF_ID_MDUStart && ~w_stall && ~reset;
    assign MDU_Busy    = (r_state == BUSY);
    assign MDU_Done    = MDU_Busy && (r_cnt == '0) && ~reset;
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (r_state == IDLE) begin
            if (MDU_Issue) begin
                w_state_next = BUSY;
                w_cnt_next   = IF_ID_MDUDiv ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
            end
        end else begin
            w_state_next = (r_cnt == '0) ? IDLE : BUSY;
            w_cnt_next   = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end
endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// tb_pipeline_interlock_ctrl: directed vectors with hand-computed strobe patterns.
// Vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, Stall, MDU_Issue, MDU_Busy, MDU_Done}.
module tb_pipeline_interlock_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic ID_EX_MemRead;
    logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
    logic IF_ID_UsesRt, IF_ID_MDUStart, IF_ID_MDUDiv, IF_ID_ReadHiLo, Branch_Taken;
    logic PCWrite, IF_ID_Write, IF_ID_Flush, Stall, MDU_Issue, MDU_Busy, MDU_Done;
    int n_cmp = 0;
    int n_bad = 0;
    localparam logic [6:0] RUN   = 7'b1100000;
    localparam logic [6:0] LU    = 7'b0001000;
    localparam logic [6:0] ISS   = 7'b1100100;
    localparam logic [6:0] BSY   = 7'b1100010;
    localparam logic [6:0] DONE  = 7'b1100011;
    localparam logic [6:0] SBSY  = 7'b0001010;
    localparam logic [6:0] SDONE = 7'b0001011;
    always #5 clk = ~clk;
    pipeline_interlock_ctrl dut (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
        .IF_ID_MDUStart(IF_ID_MDUStart), .IF_ID_MDUDiv(IF_ID_MDUDiv),
        .IF_ID_ReadHiLo(IF_ID_ReadHiLo), .Branch_Taken(Branch_Taken),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .Stall(Stall), .MDU_Issue(MDU_Issue), .MDU_Busy(MDU_Busy), .MDU_Done(MDU_Done)
    );
    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge clk);
        chk(tag, {PCWrite, IF_ID_Write, IF_ID_Flush, Stall, MDU_Issue, MDU_Busy, MDU_Done}, exp);
        @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs();
        ID_EX_MemRead = 0; ID_EX_Rt = 0; IF_ID_Rs = 0; IF_ID_Rt = 0; IF_ID_UsesRt = 0;
        IF_ID_MDUStart = 0; IF_ID_MDUDiv = 0; IF_ID_ReadHiLo = 0; Branch_Taken = 0;
    endtask
    initial begin
        reset = 1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc("reset_idle", RUN);
        ID_EX_MemRead = 1; ID_EX_Rt = 8; IF_ID_Rs = 8; Branch_Taken = 1; IF_ID_MDUStart = 1;
        cyc("reset_forces", RUN);
        idle_inputs();
        reset = 0;
        ID_EX_MemRead = 1; ID_EX_Rt = 8; IF_ID_Rs = 8;
        cyc("lu_rs", LU);
        ID_EX_MemRead = 0;
        cyc("lu_release", RUN);
        ID_EX_MemRead = 1; ID_EX_Rt = 0; IF_ID_Rs = 0;
        cyc("lu_r0", RUN);
        ID_EX_Rt = 8; IF_ID_Rs = 3; IF_ID_Rt = 8; IF_ID_UsesRt = 0;
        cyc("lu_rt_unused", RUN);
        IF_ID_UsesRt = 1;
        cyc("lu_rt_used", LU);
        idle_inputs();
        IF_ID_MDUStart = 1;
        cyc("mul_issue", ISS);
        IF_ID_MDUStart = 0;
        for (int i = 1; i <= 3; i++) cyc($sformatf("mul_busy%0d", i), BSY);
        cyc("mul_done", DONE);
        cyc("mul_idle", RUN);
        IF_ID_MDUStart = 1;
        cyc("b2b_issue0", ISS);
        for (int i = 1; i <= 3; i++) cyc($sformatf("b2b_stall%0d", i), SBSY);
        cyc("b2b_stall_done", SDONE);
        cyc("b2b_issue5", ISS);
        IF_ID_MDUStart = 0;
        for (int i = 6; i <= 8; i++) cyc($sformatf("b2b_busy%0d", i), BSY);
        cyc("b2b_done9", DONE);
        cyc("b2b_idle", RUN);
        IF_ID_MDUStart = 1; IF_ID_MDUDiv = 1;
        cyc("div_issue", ISS);
        IF_ID_MDUStart = 0; IF_ID_MDUDiv = 0; IF_ID_ReadHiLo = 1;
        for (int i = 1; i <= 31; i++) cyc($sformatf("div_mflo_stall%0d", i), SBSY);
        cyc("div_mflo_done32", SDONE);
        cyc("div_mflo_go33", RUN);
        idle_inputs();
        ID_EX_MemRead = 1; ID_EX_Rt = 8; IF_ID_Rs = 8; Branch_Taken = 1;
        cyc("br_stalled", LU);
        ID_EX_MemRead = 0;
        cyc("br_flush", 7'b1110000);
        IF_ID_MDUStart = 1;
        cyc("br_with_issue", 7'b1110100);
        idle_inputs();
        for (int i = 1; i <= 3; i++) cyc($sformatf("br_mul_busy%0d", i), BSY);
        cyc("br_mul_done", DONE);
        IF_ID_MDUStart = 1;
        cyc("both_issue", ISS);
        IF_ID_MDUStart = 0; IF_ID_ReadHiLo = 1;
        ID_EX_MemRead = 1; ID_EX_Rt = 9; IF_ID_Rs = 9;
        cyc("both_lu_mi", SBSY);
        IF_ID_ReadHiLo = 0;
        cyc("both_lu_only", SBSY);
        ID_EX_MemRead = 0;
        cyc("both_clear", BSY);
        cyc("both_done", DONE);
        idle_inputs();
        IF_ID_MDUStart = 1; IF_ID_MDUDiv = 1;
        cyc("rst_div_issue", ISS);
        IF_ID_MDUStart = 0; IF_ID_MDUDiv = 0; IF_ID_ReadHiLo = 1;
        for (int i = 1; i <= 9; i++) cyc($sformatf("rst_div_stall%0d", i), SBSY);
        reset = 1;
        cyc("rst_div_c10", BSY);
        reset = 0;
        for (int i = 11; i <= 40; i++) cyc($sformatf("rst_div_after%0d", i), RUN);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_interlock_ctrl.md
Name: pipeline_interlock_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Merges three sources into one set of IF/ID control strobes:
  - load-use hazard detection;
  - taken-branch flush;
  - interlock for a multi-cycle multiply/divide unit (MDU).
- Owns the MDU busy/latency sequencer (counter FSM), so HI/LO consumers and back-to-back MDU ops stall until the result is ready.
- Sits beside the ID stage and drives PC, IF/ID and ID/EX control.

Parameters:
REG_W, 5, register-number width
MUL_CYCLES, 4, MDU multiply latency in cycles (>=2)
DIV_CYCLES, 32, MDU divide latency in cycles (>=2, >=MUL_CYCLES)
CNT_W, 6, counter width; must hold DIV_CYCLES-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_Rt  input  REG_W  load destination register
IF_ID_Rs  input  REG_W  rs of instruction in ID
IF_ID_Rt  input  REG_W  rt of instruction in ID
IF_ID_UsesRt  input  1  ID instruction reads rt as a source
IF_ID_MDUStart  input  1  ID instruction is mult/multu/div/divu
IF_ID_MDUDiv  input  1  with MDUStart: 1=divide, 0=multiply
IF_ID_ReadHiLo  input  1  ID instruction is mfhi/mflo
Branch_Taken  input  1  branch/jump resolved taken in ID
PCWrite  output  1  PC update enable
IF_ID_Write  output  1  IF/ID register write enable
IF_ID_Flush  output  1  zero IF/ID register (squash fetched instr)
Stall  output  1  insert bubble into ID/EX (zero control bits)
MDU_Issue  output  1  start pulse to MDU datapath
MDU_Busy  output  1  MDU operation in flight
MDU_Done  output  1  one-cycle pulse, HI/LO valid this cycle

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - FSM state=IDLE, counter=0, MDU_Busy=0, MDU_Done=0.
  - While reset is high, combinational outputs are forced to PCWrite=1, IF_ID_Write=1, Stall=0, IF_ID_Flush=0, MDU_Issue=0.
- Load-use hazard (combinational): lu = ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt==IF_ID_Rt)).
  - Rs match alone stalls; Rt match only if IF_ID_UsesRt. Register 0 never stalls.
- MDU interlock (combinational): mi = MDU_Busy && (IF_ID_MDUStart || IF_ID_ReadHiLo).
- stall_any = lu || mi.
- Derived outputs:
  - PCWrite = IF_ID_Write = ~stall_any.
  - Stall = stall_any.
  - IF_ID_Flush = Branch_Taken && ~stall_any. A stalled branch is re-evaluated next cycle, so no flush while stalled.
- MDU_Issue = IF_ID_MDUStart && ~stall_any && ~reset. Issue is accepted in the same cycle.
- FSM states:
  - IDLE: on MDU_Issue, load counter with DIV_CYCLES-1 if IF_ID_MDUDiv, else MUL_CYCLES-1; go to BUSY.
  - BUSY: MDU_Busy=1. Counter decrements each cycle. When counter==0: MDU_Done=1 for that cycle, next state IDLE.
- Latency:
  - Issue at cycle N gives MDU_Busy high for cycles N+1..N+L, where L is the op latency.
  - MDU_Done is asserted at cycle N+L; MDU_Busy is low at N+L+1.
  - Dependent mfhi/mflo or a new MDU op stalls through cycle N+L and proceeds (issues) at N+L+1.
- Simultaneous events:
  - lu and mi together: single stall; both must clear before advancing.
  - Branch_Taken with stall: no flush.
  - Branch_Taken with MDU_Issue, no stall: both asserted; MDU op is in ID and proceeds, fetched instr is flushed.
- No issue while BUSY is possible: mi blocks it.
- Reset during BUSY: aborts the op. Counter=0, no MDU_Done pulse, any pending stall released on the first cycle after reset.
- Counter never wraps: it is only decremented in BUSY while >0.

Test Plan:
- Load-use: MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> PCWrite=0, IF_ID_Write=0, Stall=1 for that cycle; drop MemRead next cycle -> all released. Repeat with ID_EX_Rt=0 -> no stall. Rt=8 match with UsesRt=0 -> no stall.
- Multiply: MDUStart=1, MDUDiv=0 at cycle 0 -> MDU_Issue=1 at 0, MDU_Busy=1 cycles 1-4, MDU_Done=1 at cycle 4 only, Busy=0 at cycle 5.
- Divide then mflo: issue div at cycle 0, ReadHiLo=1 from cycle 1 -> Stall=1 cycles 1-32, PCWrite=1 at cycle 33.
- Back-to-back mult: second MDUStart held from cycle 1 -> stalled cycles 1-4, MDU_Issue=1 at cycle 5, Done at cycle 9.
- Branch_Taken=1 with lu=1 -> IF_ID_Flush=0, Stall=1; hazard clears next cycle with Branch_Taken still 1 -> IF_ID_Flush=1, PCWrite=1.
- Reset asserted at cycle 10 of a divide -> MDU_Busy=0 from cycle 11, no MDU_Done pulse, ReadHiLo no longer stalls.
